dbus_access_ctrl: RTL and testbench

Memory-stage sequencer between the pipeline's load/store unit and the data bus. It accepts at most one access at a time and checks alignment. For stores it places write data and byte strobes on the correct lanes; for loads it extracts the addressed bytes and sign- or zero-extends them. It runs the two-phase dbus handshake (`addr_ok`, then `data_ok`) and holds the pipeline with `stall` until the access retires.

---
 rtl/dbus_access_ctrl_pkg.sv | 34 +++
 rtl/dbus_access_ctrl_load_extract.sv | 26 ++
 rtl/dbus_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dbus_access_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_access_ctrl_pkg.sv
// Shared types for the data-bus access sequencer.
// Access sizes, bus word types and the sequencer state encoding.
package dbus_access_ctrl_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  strobe_t;
   typedef logic [1:0]  u2;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2
   } msize_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } dbus_state_t;

   function automatic logic is_misaligned(input u2 size, input u2 lo);
      logic bad;
      bad = 1'b0;
      unique case (size)
         2'd0: bad = 1'b0;
         2'd1: bad = lo[0];
         2'd2: bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dbus_access_ctrl_load_extract.sv
// Load data extraction: shift the addressed bytes down to lane 0,
// then sign- or zero-extend them to a full word.
module load_extract
   import dbus_access_ctrl_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  msize_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   word_t shifted;

   assign shifted = raw_i >> {addr_i, 3'b000};

   always_comb begin
      data_o = shifted;
      unique case (msize_i)
         2'd0: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
         2'd1: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/dbus_access_ctrl.sv
// Memory-stage sequencer for the data bus: one access in flight,
// alignment check, lane placement and the addr_ok/data_ok handshake.
module dbus_access_ctrl
   import dbus_access_ctrl_pkg::*;
#(
   parameter int ALIGN_CHECK = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_msize,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [1:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign
);

   dbus_state_t state_q, state_d;
   logic        kill_q, kill_d;
   logic        valid_q, valid_d;
   word_t       addr_q;
   u2           size_q;
   strobe_t     strobe_q;
   word_t       data_q;
   logic        write_q;
   logic        uns_q;
   word_t       rdata_q;

   logic        accept;
   logic        complete;
   logic        killed;
   word_t       lane_data;
   strobe_t     lane_strobe;
   word_t       ext_data;

   assign misalign = (ALIGN_CHECK != 0) && req_valid
                   && is_misaligned(req_msize, req_addr[1:0]);

   assign accept = (state_q == S_IDLE) && req_valid
                 && !misalign && !flush;

   assign complete = ((state_q == S_ADDR) && dresp_addr_ok && dresp_data_ok)
                   || ((state_q == S_DATA) && dresp_data_ok);

   // A flush arriving in the completing cycle squashes the access too.
   assign killed = kill_q || flush;

   always_comb begin
      lane_data   = req_wdata;
      lane_strobe = 4'b1111;
      unique case (req_msize)
         2'd0: begin
            lane_data   = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            lane_strobe = 4'b0001 << req_addr[1:0];
         end
         2'd1: begin
            lane_data   = {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
            lane_strobe = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            lane_data   = req_wdata;
            lane_strobe = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      valid_d = valid_q;
      stall   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               stall   = 1'b1;
               valid_d = 1'b1;
               kill_d  = 1'b0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            stall = 1'b1;
            if (flush) kill_d = 1'b1;
            if (dresp_addr_ok) begin
               valid_d = 1'b0;
               if (dresp_data_ok) begin
                  state_d = killed ? S_IDLE : S_DONE;
                  kill_d  = 1'b0;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            stall = 1'b1;
            if (flush) kill_d = 1'b1;
            if (dresp_data_ok) begin
               state_d = killed ? S_IDLE : S_DONE;
               kill_d  = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         kill_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         data_q   <= '0;
         write_q  <= 1'b0;
         uns_q    <= 1'b0;
      end else if (accept) begin
         addr_q   <= req_addr;
         size_q   <= req_msize;
         strobe_q <= req_write ? lane_strobe : 4'b0000;
         data_q   <= req_write ? lane_data : 32'b0;
         write_q  <= req_write;
         uns_q    <= req_unsigned;
      end
   end

   load_extract u_extract (
      .raw_i      (dresp_data),
      .addr_i     (addr_q[1:0]),
      .msize_i    (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext_data)
   );

   // Only retiring loads refresh rdata; stores and squashed loads keep it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (complete && !killed && !write_q) begin
         rdata_q <= ext_data;
      end
   end

   assign dreq_valid  = valid_q;
   assign dreq_addr   = addr_q;
   assign dreq_size   = size_q;
   assign dreq_strobe = strobe_q;
   assign dreq_data   = data_q;
   assign done        = (state_q == S_DONE);
   assign rdata       = rdata_q;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Directed bench for dbus_access_ctrl with hand-computed expectations.
// A second instance with ALIGN_CHECK=0 shares the same stimulus.
module tb_dbus_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_msize;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        flush;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] dresp_data;

   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        misalign;

   logic        v1;
   logic [31:0] a1;
   logic [1:0]  s1;
   logic [3:0]  st1;
   logic [31:0] d1;
   logic        stall1;
   logic        done1;
   logic [31:0] rdata1;
   logic        mis1;

   int errors = 0;
   int checks = 0;

   dbus_access_ctrl #(.ALIGN_CHECK(1)) u0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_msize(req_msize),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .flush(flush),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
      .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
      .dreq_data(dreq_data),
      .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok),
      .dresp_data(dresp_data),
      .stall(stall), .done(done), .rdata(rdata),
      .misalign(misalign)
   );

   dbus_access_ctrl #(.ALIGN_CHECK(0)) u1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_msize(req_msize),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .flush(flush),
      .dreq_valid(v1), .dreq_addr(a1),
      .dreq_size(s1), .dreq_strobe(st1),
      .dreq_data(d1),
      .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok),
      .dresp_data(dresp_data),
      .stall(stall1), .done(done1), .rdata(rdata1),
      .misalign(mis1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic wr, input logic [31:0] ad,
                      input logic [1:0] sz, input logic un,
                      input logic [31:0] wd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = ad;
      req_msize    = sz;
      req_unsigned = un;
      req_wdata    = wd;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_msize = 0;
      req_unsigned = 0; req_wdata = 0; flush = 0;
      addr_ok = 0; data_ok = 0; dresp_data = 0;
      cyc(); cyc();
      chk("rst_valid", 32'(dreq_valid), 32'd0);
      chk("rst_addr", dreq_addr, 32'd0);
      chk("rst_data", dreq_data, 32'd0);
      chk("rst_strobe", 32'(dreq_strobe), 32'd0);
      chk("rst_size", 32'(dreq_size), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      reset = 1'b0;
      cyc();

      // store byte, minimum latency
      req(1'b1, 32'h1003, 2'd0, 1'b0, 32'h123456AB);
      #2;
      chk("sb_stall_c0", 32'(stall), 32'd1);
      chk("sb_valid_c0", 32'(dreq_valid), 32'd0);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      #2;
      chk("sb_valid_c1", 32'(dreq_valid), 32'd1);
      chk("sb_addr", dreq_addr, 32'h1003);
      chk("sb_data", dreq_data, 32'hAB000000);
      chk("sb_strobe", 32'(dreq_strobe), 32'b1000);
      chk("sb_size", 32'(dreq_size), 32'd0);
      chk("sb_stall_c1", 32'(stall), 32'd1);
      chk("sb_done_c1", 32'(done), 32'd0);
      cyc();
      addr_ok = 0; data_ok = 0;
      #2;
      chk("sb_done_c2", 32'(done), 32'd1);
      chk("sb_stall_c2", 32'(stall), 32'd0);
      chk("sb_valid_c2", 32'(dreq_valid), 32'd0);
      cyc();
      chk("sb_done_c3", 32'(done), 32'd0);

      // store half at lane 2
      req(1'b1, 32'h1002, 2'd1, 1'b0, 32'hAAAA5678);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      #2;
      chk("sh_data", dreq_data, 32'h56780000);
      chk("sh_strobe", 32'(dreq_strobe), 32'b1100);
      cyc();
      addr_ok = 0; data_ok = 0;
      cyc();

      // signed then unsigned half load
      req(1'b0, 32'h2002, 2'd1, 1'b0, 32'hFFFFFFFF);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      dresp_data = 32'h8001FFFF;
      #2;
      chk("lh_strobe", 32'(dreq_strobe), 32'd0);
      cyc();
      addr_ok = 0; data_ok = 0; dresp_data = 0;
      #2;
      chk("lh_done", 32'(done), 32'd1);
      chk("lh_rdata", rdata, 32'hFFFF8001);
      cyc();
      chk("lh_hold", rdata, 32'hFFFF8001);
      req(1'b0, 32'h2002, 2'd1, 1'b1, 32'h0);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      dresp_data = 32'h8001FFFF;
      cyc();
      addr_ok = 0; data_ok = 0;
      #2;
      chk("lhu_rdata", rdata, 32'h00008001);
      cyc();

      // split handshake with waits
      req(1'b1, 32'h4000, 2'd2, 1'b0, 32'hDEADBEEF);
      cyc();
      req_valid = 0;
      for (int i = 1; i <= 3; i++) begin
         #2;
         chk("sp_valid_wait", 32'(dreq_valid), 32'd1);
         chk("sp_addr_wait", dreq_addr, 32'h4000);
         chk("sp_data_wait", dreq_data, 32'hDEADBEEF);
         chk("sp_done_wait", 32'(done), 32'd0);
         cyc();
      end
      addr_ok = 1;
      #2;
      chk("sp_valid_c4", 32'(dreq_valid), 32'd1);
      chk("sp_strobe_c4", 32'(dreq_strobe), 32'hF);
      cyc();
      addr_ok = 0;
      #2;
      chk("sp_valid_c5", 32'(dreq_valid), 32'd0);
      chk("sp_stall_c5", 32'(stall), 32'd1);
      chk("sp_done_c5", 32'(done), 32'd0);
      cyc();
      data_ok = 1;
      #2;
      chk("sp_done_c6", 32'(done), 32'd0);
      cyc();
      data_ok = 0;
      #2;
      chk("sp_done_c7", 32'(done), 32'd1);
      chk("sp_stall_c7", 32'(stall), 32'd0);
      cyc();

      // misalignment, checked with flush held so nothing is accepted
      flush = 1;
      req(1'b0, 32'h3003, 2'd3, 1'b0, 32'h0);
      #2;
      chk("mis_sz3", 32'(misalign), 32'd1);
      chk("mis_sz3_nochk", 32'(mis1), 32'd0);
      req(1'b0, 32'h3001, 2'd1, 1'b0, 32'h0);
      #2;
      chk("mis_half_odd", 32'(misalign), 32'd1);
      req(1'b0, 32'h3002, 2'd1, 1'b0, 32'h0);
      #2;
      chk("mis_half_ok", 32'(misalign), 32'd0);
      chk("flush_idle_stall", 32'(stall), 32'd0);
      cyc();
      chk("flush_idle_valid", 32'(dreq_valid), 32'd0);
      flush = 0;

      req(1'b0, 32'h3001, 2'd2, 1'b0, 32'h0);
      #2;
      chk("mw_misalign", 32'(misalign), 32'd1);
      chk("mw_stall", 32'(stall), 32'd0);
      chk("mw_stall_nochk", 32'(stall1), 32'd1);
      cyc();
      req_valid = 0;
      #2;
      chk("mw_valid", 32'(dreq_valid), 32'd0);
      chk("mw_valid_nochk", 32'(v1), 32'd1);
      chk("mw_addr_nochk", a1, 32'h3001);
      addr_ok = 1; data_ok = 1;
      cyc();
      addr_ok = 0; data_ok = 0;
      #2;
      chk("mw_done", 32'(done), 32'd0);
      chk("mw_done_nochk", 32'(done1), 32'd1);
      cyc();

      // signed byte load, then a flushed word load
      req(1'b0, 32'h2001, 2'd0, 1'b0, 32'h0);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      dresp_data = 32'h1234F600;
      cyc();
      addr_ok = 0; data_ok = 0;
      #2;
      chk("lb_rdata", rdata, 32'hFFFFFFF6);
      cyc();
      req(1'b0, 32'h5000, 2'd2, 1'b0, 32'h0);
      cyc();
      req_valid = 0; addr_ok = 1;
      cyc();
      addr_ok = 0; flush = 1;
      #2;
      chk("fl_stall_data", 32'(stall), 32'd1);
      cyc();
      flush = 0;
      #2;
      chk("fl_stall_wait", 32'(stall), 32'd1);
      data_ok = 1; dresp_data = 32'h11111111;
      cyc();
      data_ok = 0;
      req(1'b0, 32'h6000, 2'd2, 1'b0, 32'h0);
      #2;
      chk("fl_done", 32'(done), 32'd0);
      chk("fl_rdata", rdata, 32'hFFFFFFF6);
      chk("fl_idle_accept", 32'(stall), 32'd1);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      dresp_data = 32'hCAFE0001;
      cyc();
      addr_ok = 0; data_ok = 0;
      flush = 1;
      #2;
      chk("fdone_done", 32'(done), 32'd1);
      chk("fdone_rdata", rdata, 32'hCAFE0001);
      cyc();
      flush = 0;

      // asynchronous reset while in ADDR
      req(1'b1, 32'h7004, 2'd2, 1'b0, 32'h55AA55AA);
      cyc();
      req_valid = 0;
      #2;
      chk("ra_valid_pre", 32'(dreq_valid), 32'd1);
      reset = 1;
      #1;
      chk("ra_valid", 32'(dreq_valid), 32'd0);
      chk("ra_addr", dreq_addr, 32'd0);
      chk("ra_data", dreq_data, 32'd0);
      chk("ra_strobe", 32'(dreq_strobe), 32'd0);
      chk("ra_rdata", rdata, 32'd0);
      chk("ra_stall", 32'(stall), 32'd0);
      cyc();
      reset = 0;
      cyc();
      chk("ra_noreplay", 32'(dreq_valid), 32'd0);
      req(1'b0, 32'h7006, 2'd1, 1'b1, 32'h0);
      #2;
      chk("ra_accept", 32'(stall), 32'd1);
      cyc();
      req_valid = 0; addr_ok = 1; data_ok = 1;
      dresp_data = 32'hBEEF0000;
      cyc();
      addr_ok = 0; data_ok = 0;
      #2;
      chk("ra_done", 32'(done), 32'd1);
      chk("ra_rdata_new", rdata, 32'h0000BEEF);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
